// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4-style accumulator CPU.
//   Registers A and B, a carry flag C and an instruction pointer ip.
//   Writable program memory (2**ADDR_W words of {imm, op}).
//   Run/stop/halt control FSM.
//   Execution is gated by tick: one instruction retires per RUN cycle with tick=1.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   tick       execute enable
//   start      pulse: clear A/B/C/ip, enter RUN (wins over stop)
//   stop       pulse: RUN -> IDLE, state retained
//   prog_we    program memory write strobe (ignored in RUN)
//   prog_addr  program write address
//   prog_data  instruction word {imm[DATA_W-1:0], op[3:0]}
//   in_port    input switches
//   out_port   registered output latch
//   ip_o       current instruction pointer
//   cflag_o    carry flag
//   running    FSM in RUN
//   halted     FSM in HALT
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [ADDR_W-1:0] ip_o,
  output logic              cflag_o,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_HLT    = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_NOP_A  = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_NOP_C  = 4'b1100,
    OP_NOP_D  = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } op_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_c;
  logic [ADDR_W-1:0]   r_ip;
  logic [DATA_W-1:0]   r_out;
  logic [DATA_W+3:0]   r_mem [2**ADDR_W];

  logic [DATA_W+3:0]   w_instr;
  op_t                 w_op;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_src;
  logic [DATA_W:0]     w_sum;
  logic                w_wr_a;
  logic                w_wr_b;
  logic                w_wr_o;
  logic                w_wr_c;
  logic                w_jump;
  logic                w_retire;
  logic [ADDR_W-1:0]   w_ip_nxt;

  // Program memory: synchronous write, combinational read at ip.
  // Writes are locked out while the program is running.
  always_ff @(posedge clock) begin
    if (prog_we && (r_state != S_RUN)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign w_instr = r_mem[r_ip];
  assign w_op    = op_t'(w_instr[3:0]);
  assign w_imm   = w_instr[DATA_W+3:4];

  // Decode: source select and destination enables.
  always_comb begin
    w_src  = '0;
    w_wr_a = 1'b0;
    w_wr_b = 1'b0;
    w_wr_o = 1'b0;
    w_wr_c = 1'b1;
    w_jump = 1'b0;
    case (w_op)
      OP_ADD_A:  begin w_src = r_a;     w_wr_a = 1'b1; end
      OP_MOV_AB: begin w_src = r_b;     w_wr_a = 1'b1; end
      OP_IN_A:   begin w_src = in_port; w_wr_a = 1'b1; end
      OP_MOV_AI: begin                  w_wr_a = 1'b1; end
      OP_MOV_BA: begin w_src = r_a;     w_wr_b = 1'b1; end
      OP_ADD_B:  begin w_src = r_b;     w_wr_b = 1'b1; end
      OP_IN_B:   begin w_src = in_port; w_wr_b = 1'b1; end
      OP_MOV_BI: begin                  w_wr_b = 1'b1; end
      OP_OUT_B:  begin w_src = r_b;     w_wr_o = 1'b1; end
      OP_OUT_I:  begin                  w_wr_o = 1'b1; end
      OP_JNC:    begin w_jump = ~r_c; end
      OP_JMP:    begin w_jump = 1'b1; end
      OP_HLT, OP_NOP_A, OP_NOP_C, OP_NOP_D: begin w_wr_c = 1'b0; end
      default:   begin w_wr_c = 1'b0; end
    endcase
  end

  assign w_sum = {1'b0, w_src} + {1'b0, w_imm};

  always_comb begin
    if (w_jump) begin
      w_ip_nxt = w_imm[ADDR_W-1:0];
    end else if (w_op == OP_HLT) begin
      w_ip_nxt = r_ip;
    end else begin
      w_ip_nxt = r_ip + ADDR_W'(1);
    end
  end

  // start and stop both pre-empt retirement in their cycle.
  assign w_retire = (r_state == S_RUN) && tick && !start && !stop;

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (stop) begin
            w_state_nxt = S_IDLE;
          end else if (w_retire && (w_op == OP_HLT)) begin
            w_state_nxt = S_HALT;
          end
        end
        S_HALT: begin
          if (stop) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_ip  <= '0;
      r_out <= '0;
    end else if (start) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= 1'b0;
      r_ip <= '0;
    end else if (w_retire) begin
      if (w_wr_a) r_a   <= w_sum[DATA_W-1:0];
      if (w_wr_b) r_b   <= w_sum[DATA_W-1:0];
      if (w_wr_o) r_out <= w_sum[DATA_W-1:0];
      if (w_wr_c) r_c   <= w_sum[DATA_W];
      r_ip <= w_ip_nxt;
    end
  end

  assign out_port = r_out;
  assign ip_o     = r_ip;
  assign cflag_o  = r_c;
  assign running  = (r_state == S_RUN);
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_td4_core_param.sv
// tb_td4_core_param: directed self-checking bench for td4_core_param.
//   dut  : default DATA_W=4, ADDR_W=4
//   dut2 : DATA_W=8, ADDR_W=5 (wide carry case)
module tb_td4_core_param;

  localparam logic [3:0] ADD_A = 4'h0, MOV_AI = 4'h3, MOV_BA = 4'h4,
                         ADD_B = 4'h5, MOV_BI = 4'h7, HLT = 4'h8,
                         OUT_B = 4'h9, NOP = 4'hA, JNC = 4'hE, JMP = 4'hF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, we = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] data = '0;
  logic [3:0] inp = '0;
  logic [3:0] outp;
  logic [3:0] ip;
  logic       cf, run, hlt;

  logic        tick2 = 1'b0, start2 = 1'b0, stop2 = 1'b0, we2 = 1'b0;
  logic [4:0]  addr2 = '0;
  logic [11:0] data2 = '0;
  logic [7:0]  inp2 = '0;
  logic [7:0]  outp2;
  logic [4:0]  ip2;
  logic        cf2, run2, hlt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  td4_core_param #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .prog_we(we), .prog_addr(addr), .prog_data(data), .in_port(inp),
    .out_port(outp), .ip_o(ip), .cflag_o(cf), .running(run), .halted(hlt)
  );

  td4_core_param #(.DATA_W(8), .ADDR_W(5)) dut2 (
    .clock(clock), .reset(reset), .tick(tick2), .start(start2), .stop(stop2),
    .prog_we(we2), .prog_addr(addr2), .prog_data(data2), .in_port(inp2),
    .out_port(outp2), .ip_o(ip2), .cflag_o(cf2), .running(run2), .halted(hlt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] imm, input logic [3:0] op);
    addr = a; data = {imm, op}; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic load2(input logic [4:0] a, input logic [7:0] imm, input logic [3:0] op);
    addr2 = a; data2 = {imm, op}; we2 = 1'b1;
    step();
    we2 = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic exec(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    // Reset state (async, checked while reset is still low)
    #2;
    check("rst_out", outp, 0);
    check("rst_ip", ip, 0);
    check("rst_c", cf, 0);
    check("rst_run", run, 0);
    check("rst_hlt", hlt, 0);
    step();
    reset = 1'b1;
    step();

    // 3+4 -> B -> OUT, then HLT
    load(0, 3, MOV_AI); load(1, 4, ADD_A); load(2, 0, MOV_BA);
    load(3, 0, OUT_B);  load(4, 0, HLT);
    go();
    check("go_ip", ip, 0);
    check("go_run", run, 1);
    exec(4);
    check("p1_out", outp, 7);
    check("p1_ip4", ip, 4);
    exec(1);
    check("p1_hlt", hlt, 1);
    check("p1_run", run, 0);
    check("p1_iph", ip, 4);

    // Async reset mid-RUN with A=5, memory must survive
    load(0, 5, MOV_AI); load(1, 0, MOV_BA); load(2, 0, OUT_B); load(3, 0, HLT);
    go();
    exec(2);
    check("pre_a", dut.r_a, 5);
    reset = 1'b0;
    #1;
    check("mr_ip", ip, 0);
    check("mr_out", outp, 0);
    check("mr_c", cf, 0);
    check("mr_run", run, 0);
    check("mr_a", dut.r_a, 0);
    check("mr_b", dut.r_b, 0);
    step();
    reset = 1'b1;
    step();
    go();
    exec(4);
    check("mem_out", outp, 5);
    check("mem_hlt", hlt, 1);
    check("mem_ip", ip, 3);

    // Carry and JNC not taken
    load(0, 4'hF, MOV_AI); load(1, 1, ADD_A); load(2, 9, JNC);
    load(3, 0, HLT); load(9, 0, HLT);
    go();
    check("st_out", outp, 5);
    check("st_hlt", hlt, 0);
    exec(2);
    check("cy_c", cf, 1);
    check("cy_a", dut.r_a, 0);
    exec(1);
    check("jnc_nt_ip", ip, 3);
    check("jnc_c", cf, 0);
    exec(1);
    check("jnc_nt_h", hlt, 1);

    // JNC taken with C=0
    load(1, 0, ADD_A);
    go();
    exec(2);
    check("nc_c", cf, 0);
    exec(1);
    check("jnc_t_ip", ip, 9);
    exec(1);
    check("jnc_t_h", hlt, 1);
    check("jnc_t_ih", ip, 9);

    // tick gating: 1,0,0,1
    load(0, 1, MOV_AI); load(1, 1, ADD_A); load(2, 0, MOV_BA);
    load(3, 0, OUT_B); load(4, 0, HLT);
    go();
    tick = 1'b1; step();
    check("tk_ip1", ip, 1);
    tick = 1'b0; step();
    check("tk_ip1b", ip, 1);
    step();
    check("tk_ip1c", ip, 1);
    check("tk_a1", dut.r_a, 1);
    tick = 1'b1; step();
    tick = 1'b0;
    check("tk_ip2", ip, 2);
    check("tk_a2", dut.r_a, 2);
    exec(3);
    check("tk_out", outp, 2);
    check("tk_hlt", hlt, 1);

    // prog_we in RUN is ignored; stop suppresses retirement; start beats stop
    load(0, 3, MOV_BI); load(1, 0, OUT_B); load(2, 0, JMP);
    go();
    exec(1);
    addr = 2; data = {4'h0, HLT}; we = 1'b1; tick = 1'b1;
    step();
    we = 1'b0; tick = 1'b0;
    check("we_ip2", ip, 2);
    exec(1);
    check("we_ip0", ip, 0);
    check("we_run", run, 1);
    check("we_out", outp, 3);
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    check("sp_run", run, 0);
    check("sp_ip", ip, 0);
    go();
    exec(3);
    check("rr_ip", ip, 0);
    check("rr_run", run, 1);
    exec(1);
    check("rr_ip1", ip, 1);
    start = 1'b1; stop = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    check("ss_ip", ip, 0);
    check("ss_run", run, 1);
    stop = 1'b1; step(); stop = 1'b0;

    // ip wrap 15 -> 0 with straight-line NOPs
    for (int i = 0; i < 16; i++) load(4'(i), 0, NOP);
    go();
    exec(15);
    check("wr_ip15", ip, 15);
    exec(1);
    check("wr_ip0", ip, 0);
    check("wr_run", run, 1);
    stop = 1'b1; step(); stop = 1'b0;

    // DATA_W=8, ADDR_W=5: 1 + 0xFF -> 0x00 with carry
    load2(0, 8'h01, MOV_AI); load2(1, 8'hFF, ADD_A); load2(2, 8'h00, MOV_BA);
    load2(3, 8'h33, ADD_B);  load2(4, 8'h00, OUT_B); load2(5, 8'h00, HLT);
    start2 = 1'b1; step(); start2 = 1'b0;
    tick2 = 1'b1;
    repeat (2) step();
    check("w8_c", cf2, 1);
    check("w8_a", dut2.r_a, 0);
    repeat (4) step();
    tick2 = 1'b0;
    check("w8_out", outp2, 8'h33);
    check("w8_hlt", hlt2, 1);
    check("w8_ip", ip2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
